// File: rtl/ac_motor_pwm_scheduler.sv
// ---------------------------------------------------------------------------
// ac_motor_pwm_scheduler
//
// Three-phase PWM controller for the AC motor inverter. Each phase compares its
// active duty reference against the registered triangle carrier and drives a
// complementary high/low switch pair with dead time inserted on every change.
// Duty references are double-buffered: software fills a shadow set through a
// valid/ready handshake and the set becomes active at the next carrier valley.
// Switching is gated by enable, carrier lock and a latched fault.
//
// Ports:
//   clk, reset_n           clock, synchronous active-low reset
//   enable, lock           run request, carrier-locked flag
//   triangle               signed carrier sample (W bits)
//   duty_u/v/w             signed duty references for the shadow load
//   duty_valid/duty_ready  shadow load handshake
//   fault, fault_clr       hardware trip input, latch clear
//   pwm_hi, pwm_lo         switch commands [0]=U [1]=V [2]=W
//   valley                 one-cycle pulse at the carrier valley
//   fault_latched          latched fault status
// ---------------------------------------------------------------------------
module ac_motor_pwm_scheduler #(
  parameter int W        = 24,
  parameter int TRI_AMP  = 4194303,
  parameter int DEADTIME = 10
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                enable,
  input  logic                lock,
  input  logic signed [W-1:0] triangle,
  input  logic signed [W-1:0] duty_u,
  input  logic signed [W-1:0] duty_v,
  input  logic signed [W-1:0] duty_w,
  input  logic                duty_valid,
  output logic                duty_ready,
  input  logic                fault,
  input  logic                fault_clr,
  output logic [2:0]          pwm_hi,
  output logic [2:0]          pwm_lo,
  output logic                valley,
  output logic                fault_latched
);

  localparam int CW = $clog2(DEADTIME + 1);
  localparam logic [CW-1:0]       DT_LOAD = CW'(DEADTIME);
  localparam logic signed [W-1:0] AMP_POS = W'(TRI_AMP);
  localparam logic signed [W-1:0] AMP_NEG = -AMP_POS;

  typedef enum logic [1:0] {IDLE, DT, HIGH, LOW} phase_state_t;

  logic signed [W-1:0] triangle_q;
  logic                slope_down;
  logic                valley_cond;
  logic                pending;
  logic                run;
  logic signed [W-1:0] duty_in [3];
  logic signed [W-1:0] shadow  [3];
  logic signed [W-1:0] active  [3];
  logic [2:0]          demand;

  phase_state_t  state   [3];
  phase_state_t  state_n [3];
  logic          target  [3];
  logic          target_n[3];
  logic [CW-1:0] count   [3];
  logic [CW-1:0] count_n [3];

  assign duty_in[0] = duty_u;
  assign duty_in[1] = duty_v;
  assign duty_in[2] = duty_w;

  function automatic logic signed [W-1:0] saturate(input logic signed [W-1:0] d);
    if (d > AMP_POS)      return AMP_POS;
    else if (d < AMP_NEG) return AMP_NEG;
    else                  return d;
  endfunction

  // Valley: the carrier was falling and the new sample is above the last one.
  assign valley_cond = slope_down && (triangle > triangle_q);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      triangle_q <= '0;
      slope_down <= 1'b0;
      valley     <= 1'b0;
    end else begin
      triangle_q <= triangle;
      if (triangle < triangle_q)      slope_down <= 1'b1;
      else if (triangle > triangle_q) slope_down <= 1'b0;
      valley <= valley_cond;
    end
  end

  assign duty_ready = !pending;

  // NOTE: the duty buffers are only six words of flops, so they take reset
  // like the rest of the state; the inverter must come up at zero duty.
  // Transfer needs pending=1 and a load needs pending=0, so the two never
  // collide; a load accepted in the valley cycle waits for the next valley.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pending <= 1'b0;
      for (int i = 0; i < 3; i++) begin
        shadow[i] <= '0;
        active[i] <= '0;
      end
    end else if (valley && pending) begin
      pending <= 1'b0;
      for (int i = 0; i < 3; i++) active[i] <= shadow[i];
    end else if (duty_valid && duty_ready) begin
      pending <= 1'b1;
      for (int i = 0; i < 3; i++) shadow[i] <= saturate(duty_in[i]);
    end
  end

  // A live fault wins over a clear request.
  always_ff @(posedge clk) begin
    if (!reset_n)       fault_latched <= 1'b0;
    else if (fault)     fault_latched <= 1'b1;
    else if (fault_clr) fault_latched <= 1'b0;
  end

  // The raw fault is included so outputs drop in the same edge that latches it.
  assign run = enable && lock && !fault_latched && !fault;

  // NOTE: every variable gets its hold value first, so no path through the
  // case statement leaves one unassigned and no latch is inferred.
  always_comb begin
    demand = '0;
    for (int i = 0; i < 3; i++) begin
      state_n[i]  = state[i];
      target_n[i] = target[i];
      count_n[i]  = count[i];
      demand[i]   = (active[i] > triangle_q);
      if (!run) begin
        state_n[i] = IDLE;
      end else begin
        case (state[i])
          IDLE: begin
            target_n[i] = demand[i];
            count_n[i]  = DT_LOAD;
            state_n[i]  = DT;
          end
          DT: begin
            // Any demand change restarts the full dead-time window.
            if (demand[i] != target[i]) begin
              target_n[i] = demand[i];
              count_n[i]  = DT_LOAD;
            end else if (count[i] == CW'(1)) begin
              state_n[i] = target[i] ? HIGH : LOW;
            end else begin
              count_n[i] = count[i] - CW'(1);
            end
          end
          HIGH: begin
            if (!demand[i]) begin
              target_n[i] = 1'b0;
              count_n[i]  = DT_LOAD;
              state_n[i]  = DT;
            end
          end
          LOW: begin
            if (demand[i]) begin
              target_n[i] = 1'b1;
              count_n[i]  = DT_LOAD;
              state_n[i]  = DT;
            end
          end
          default: state_n[i] = IDLE;
        endcase
      end
    end
  end

  // Switch commands are registered from the next state, so they change in
  // the same edge as the phase state and are one-hot by construction.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      pwm_hi <= '0;
      pwm_lo <= '0;
      for (int i = 0; i < 3; i++) begin
        state[i]  <= IDLE;
        target[i] <= 1'b0;
        count[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        state[i]  <= state_n[i];
        target[i] <= target_n[i];
        count[i]  <= count_n[i];
        pwm_hi[i] <= (state_n[i] == HIGH);
        pwm_lo[i] <= (state_n[i] == LOW);
      end
    end
  end

endmodule

// File: doc/ac_motor_pwm_scheduler.md
Name: ac_motor_pwm_scheduler

Overview:
- Three-phase PWM controller for the AC motor inverter. It compares per-phase duty references against the shared signed triangle carrier and inserts dead time between complementary high/low switch commands.
- Duty references are double-buffered: software loads a shadow set through a valid/ready handshake, and the block transfers it to the active set only at the carrier valley.
- Gates all switching on carrier lock, enable and a latched fault.

Parameters:
- W, 24, width of triangle and duty words (signed two's complement)
- TRI_AMP, 4194303, carrier amplitude; duties clamped to [-TRI_AMP, +TRI_AMP]
- DEADTIME, 10, clk cycles both switches of a phase are held off on every transition (>=1)

Ports:
- clk  in  1  system clock
- reset_n  in  1  synchronous active-low reset
- enable  in  1  run request; 0 forces all switches off
- lock  in  1  carrier-locked flag from triangle generator
- triangle  in  W  signed carrier sample
- duty_u, duty_v, duty_w  in  W each  signed duty references for the shadow load
- duty_valid  in  1  duty set presented
- duty_ready  out  1  shadow buffer free
- fault  in  1  hardware trip; latched
- fault_clr  in  1  clears latched fault
- pwm_hi  out  3  high-side commands [0]=U [1]=V [2]=W
- pwm_lo  out  3  low-side commands, same order
- valley  out  1  one-cycle pulse at carrier valley (active-duty update instant)
- fault_latched  out  1  latched fault status

Behaviour:
- Reset (reset_n=0 at clk edge):
  - pwm_hi=pwm_lo=0, valley=0, fault_latched=0, duty_ready=1.
  - Shadow and active duties = 0; pending=0.
  - triangle_q=0, slope_down=0.
  - All phase FSMs enter IDLE.
- Reset applied mid-operation has the same effect at the next edge.
- Carrier tracking:
  - triangle registered into triangle_q each cycle.
  - slope_down set when triangle < triangle_q and cleared when triangle > triangle_q; equal samples hold it.
  - valley pulses for one cycle when slope_down=1 and triangle > triangle_q.
- Shadow handshake:
  - duty_ready = !pending.
  - On valid && ready: capture duty_u/v/w, each saturated to ±TRI_AMP, then set pending.
  - At valley with pending=1: copy shadow to active and clear pending; duty_ready returns to 1 the following cycle.
  - A handshake completing in the valley cycle (pending was 0) is not transferred until the next valley.
  - At valley with pending=0: active duties are unchanged.
- Demand per phase: demand_hi = (active_duty > triangle_q), signed compare.
- Run condition: run = enable && lock && !fault_latched && !fault.
- Phase FSM (one per phase), states IDLE, DT, HIGH, LOW:
  - IDLE: both switches off. When run=1: target := demand_hi, count := DEADTIME, go to DT.
  - DT: both switches off.
    - If demand_hi != target: target := demand_hi and count := DEADTIME (restart).
    - Else if count==1: go to HIGH if target=1, otherwise LOW.
    - Else decrement count.
  - HIGH: pwm_hi=1, pwm_lo=0. If demand_hi=0: count := DEADTIME, target := 0, go to DT.
  - LOW: pwm_lo=1, pwm_hi=0. If demand_hi=1: count := DEADTIME, target := 1, go to DT.
  - Any state with run=0: go to IDLE. This takes priority over all other transitions.
- Outputs are registered from the state.
  - pwm_hi and pwm_lo of the same phase are never 1 together in any cycle.
  - Between deassertion of one switch and assertion of its complement there are at least DEADTIME cycles with both off.
- Latency: triangle crossing at input cycle N:
  - the on-switch drops at the cycle N+2 output;
  - the complementary switch asserts at cycle N+2+DEADTIME.
- Fault handling:
  - fault=1 sets fault_latched at the next edge; outputs are forced off in that same registered update.
  - fault_clr clears the latch only when fault=0; fault wins if both are asserted.
  - Restart after clear goes through IDLE then DT, so dead time is always honoured.
- Duty boundaries:
  - duty = +TRI_AMP: the phase stays HIGH except where the triangle reaches +TRI_AMP.
  - duty = -TRI_AMP: the phase stays LOW.
  - No internal overflow; the compare is W-bit signed.

Test Plan:
- Reset release with enable=1, lock=1, active duty 0, triangle ramping ±4096 step 1 -> after DEADTIME=10 both-off cycles, each phase alternates HIGH/LOW with 10-cycle gaps of both off; hi&lo never both 1.
- duty_valid with U=+1000, V=0, W=-1000 mid-ramp -> duty_ready drops next cycle; active duties unchanged until the valley pulse; ready back to 1 one cycle after valley.
- duty_u=+5,000,000 -> saturated to 4194303; phase U stays HIGH for the whole period.
- Triangle dithers across duty with a period < DEADTIME -> phase stays in DT with both switches off until the demand is stable for 10 cycles.
- fault pulse while HIGH -> all outputs 0 at the next edge; fault_latched=1; fault_clr with fault=0 -> restart via DT (10 cycles off) before any switch asserts.
- lock dropped for 3 cycles -> all phases go to IDLE (outputs 0); on relock, DEADTIME-cycle both-off delay before switching resumes.
